// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, one step per clock.
`ifndef ALU_MUL
`define ALU_MUL    5'b10000
`endif
`ifndef ALU_MULH
`define ALU_MULH   5'b10001
`endif
`ifndef ALU_MULHSU
`define ALU_MULHSU 5'b10010
`endif
`ifndef ALU_MULHU
`define ALU_MULHU  5'b10011
`endif
`ifndef ALU_DIV
`define ALU_DIV    5'b10100
`endif
`ifndef ALU_DIVU
`define ALU_DIVU   5'b10101
`endif
`ifndef ALU_REM
`define ALU_REM    5'b10110
`endif
`ifndef ALU_REMU
`define ALU_REMU   5'b10111
`endif

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      ALU_selection,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [4:0]        sel;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic              neg_p, neg_r;

  logic            is_m, sgn_a, sgn_b, div_op;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            by_zero, ovf, accept;

  // Decode the operation code into signedness and class.
  always_comb begin
    is_m   = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    div_op = 1'b0;
    unique case (ALU_selection)
      `ALU_MUL, `ALU_MULH: begin
        is_m  = 1'b1;
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      `ALU_MULHSU: begin
        is_m  = 1'b1;
        sgn_a = 1'b1;
      end
      `ALU_MULHU: is_m = 1'b1;
      `ALU_DIV, `ALU_REM: begin
        is_m   = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
        div_op = 1'b1;
      end
      `ALU_DIVU, `ALU_REMU: begin
        is_m   = 1'b1;
        div_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign neg_a = sgn_a & op_a[XLEN-1];
  assign neg_b = sgn_b & op_b[XLEN-1];
  assign abs_a = neg_a ? -op_a : op_a;
  assign abs_b = neg_b ? -op_b : op_b;

  assign by_zero = div_op && (op_b == '0);
  assign ovf = div_op && sgn_a
            && (op_a == {1'b1, {(XLEN-1){1'b0}}})
            && (&op_b);

  assign accept = (state == IDLE) && start && is_m && !kill;
  assign busy   = (state != IDLE) || accept;

  logic [XLEN:0]     add;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     shift, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_step, quo_step;

  // One multiply step and one divide step per cycle.
  always_comb begin
    add = {1'b0, prod[2*XLEN-1:XLEN]}
        + (prod[0] ? {1'b0, mag_a} : '0);
    prod_step = {add, prod[XLEN-1:1]};
    shift = {rem, quo[XLEN-1]};
    diff  = shift - {1'b0, mag_b};
    ge    = !diff[XLEN];
    rem_step = ge ? diff[XLEN-1:0] : shift[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], ge};
  end

  logic [2*XLEN-1:0] pfix;
  logic [XLEN-1:0]   qfix, rfix, fin_val;

  // Sign fix-up and result selection for the FIN cycle.
  always_comb begin
    pfix = neg_p ? -prod : prod;
    qfix = neg_p ? -quo : quo;
    rfix = neg_r ? -rem : rem;
    fin_val = '0;
    unique case (sel)
      `ALU_MUL: fin_val = pfix[XLEN-1:0];
      `ALU_MULH, `ALU_MULHSU, `ALU_MULHU:
        fin_val = pfix[2*XLEN-1:XLEN];
      `ALU_DIV, `ALU_DIVU: fin_val = qfix;
      `ALU_REM, `ALU_REMU: fin_val = rfix;
      default: fin_val = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; kill aborts CALC/FIN.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (by_zero || ovf) ? FIN : CALC;
      CALC: begin
        if (kill)
          state_nx = IDLE;
        else if (cnt == CNT_W'(XLEN-1))
          state_nx = FIN;
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CALC, write in FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      prod   <= '0;
      quo    <= '0;
      rem    <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sel   <= ALU_selection;
        cnt   <= '0;
        mag_a <= abs_a;
        mag_b <= abs_b;
        prod  <= {{XLEN{1'b0}}, abs_b};
        if (by_zero) begin
          quo   <= '1;
          rem   <= op_a;
          neg_p <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          quo   <= {1'b1, {(XLEN-1){1'b0}}};
          rem   <= '0;
          neg_p <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= abs_a;
          rem   <= '0;
          neg_p <= neg_a ^ neg_b;
          neg_r <= neg_a;
        end
      end else if (state == CALC && !kill) begin
        cnt  <= cnt + 1'b1;
        prod <= prod_step;
        quo  <= quo_step;
        rem  <= rem_step;
      end else if (state == FIN && !kill) begin
        result <= fin_val;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit
// against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [4:0] C_ADD    = 5'b00000;
  localparam logic [4:0] C_MUL    = 5'b10000;
  localparam logic [4:0] C_MULH   = 5'b10001;
  localparam logic [4:0] C_MULHSU = 5'b10010;
  localparam logic [4:0] C_MULHU  = 5'b10011;
  localparam logic [4:0] C_DIV    = 5'b10100;
  localparam logic [4:0] C_DIVU   = 5'b10101;
  localparam logic [4:0] C_REM    = 5'b10110;
  localparam logic [4:0] C_REMU   = 5'b10111;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [4:0]  sel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ALU_selection(sel),
    .op_a(op_a),
    .op_b(op_b),
    .kill(kill),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int ia, ib;
    logic ov;
    ia = $signed(a);
    ib = $signed(b);
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (s)
      C_MUL: begin
        p = longint'(ia) * longint'(ib);
        model = p[31:0];
      end
      C_MULH: begin
        p = longint'(ia) * longint'(ib);
        model = p[63:32];
      end
      C_MULHSU: begin
        p = longint'(ia) * longint'({32'h0, b});
        model = p[63:32];
      end
      C_MULHU: begin
        u = {32'h0, a} * {32'h0, b};
        model = u[63:32];
      end
      C_DIV:
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (ov) model = 32'h8000_0000;
        else model = ia / ib;
      C_DIVU:
        if (b == 0) model = 32'hFFFF_FFFF;
        else model = a / b;
      C_REM:
        if (b == 0) model = a;
        else if (ov) model = 32'h0;
        else model = ia % ib;
      C_REMU:
        if (b == 0) model = a;
        else model = a % b;
      default: model = '0;
    endcase
  endfunction

  function automatic int latency(
    input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic is_div, is_sdiv;
    is_div  = (s == C_DIV) || (s == C_DIVU)
           || (s == C_REM) || (s == C_REMU);
    is_sdiv = (s == C_DIV) || (s == C_REM);
    if (is_div && b == 0) return 1;
    if (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run(
    input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
    input int poke, input int kill_at, input string tag);
    logic [31:0] exp;
    int n;
    logic bok;
    exp = model(s, a, b);
    start = 1'b1;
    sel   = s;
    op_a  = a;
    op_b  = b;
    #1 bok = busy;
    @(negedge clk);
    start = 1'b0;
    sel   = C_ADD;
    op_a  = $urandom;
    op_b  = $urandom;
    n = 0;
    while (!done && n < 100) begin
      if (!busy) bok = 1'b0;
      if (n == poke) begin
        start = 1'b1;
        sel   = C_DIVU;
        op_a  = 32'h0000_1234;
        op_b  = 32'd3;
      end
      kill = (n == kill_at);
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      n++;
      if (kill_at >= 0 && n > kill_at) break;
    end
    if (kill_at >= 0) begin
      chk({tag, "_kill_done"}, done, 1'b0);
      chk({tag, "_kill_busy"}, busy, 1'b0);
      chk({tag, "_kill_res"}, result, last_res);
    end else begin
      chk({tag, "_timeout"}, (n < 100), 1'b1);
      chk({tag, "_busy"}, bok, 1'b1);
      chk({tag, "_lat"}, n, latency(s, a, b));
      chk({tag, "_res"}, result, exp);
      last_res = exp;
      @(negedge clk);
      chk({tag, "_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    logic [4:0] codes [8];
    logic [4:0] s;
    logic [31:0] a, b;
    codes = '{C_MUL, C_MULH, C_MULHSU, C_MULHU,
              C_DIV, C_DIVU, C_REM, C_REMU};
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    sel = C_ADD; op_a = '0; op_b = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 1'b0);
    chk("rst_res", result, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run(C_MUL, 32'd7, 32'hFFFF_FFFD, -1, -1, "mul");
    chk("mul_const", result, 32'hFFFF_FFEB);
    run(C_MULH, 32'h8000_0000, 32'h8000_0000, -1, -1, "mulh");
    chk("mulh_const", result, 32'h4000_0000);
    run(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, "mulhu");
    chk("mulhu_const", result, 32'hFFFF_FFFE);
    run(C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, "mulhsu");
    chk("mulhsu_const", result, 32'hFFFF_FFFF);
    run(C_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, "div");
    chk("div_const", result, 32'hFFFF_FFFD);
    run(C_REM, 32'hFFFF_FFF9, 32'd2, -1, -1, "rem");
    chk("rem_const", result, 32'hFFFF_FFFF);
    run(C_DIVU, 32'hFFFF_FFFF, 32'd2, -1, -1, "divu");
    chk("divu_const", result, 32'h7FFF_FFFF);
    run(C_REMU, 32'hFFFF_FFFF, 32'd2, -1, -1, "remu");
    chk("remu_const", result, 32'h1);

    run(C_DIVU, 32'd5, 32'd0, -1, -1, "divu_z");
    chk("divu_z_const", result, 32'hFFFF_FFFF);
    run(C_REM, 32'd5, 32'd0, -1, -1, "rem_z");
    chk("rem_z_const", result, 32'd5);
    run(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "div_ov");
    chk("div_ov_const", result, 32'h8000_0000);
    run(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "rem_ov");
    chk("rem_ov_const", result, 32'h0);

    run(C_MUL, 32'd7, 32'hFFFF_FFFD, 5, -1, "poke");
    run(C_DIV, 32'd1000, 32'd7, -1, 10, "kill");
    run(C_REMU, 32'd1000, 32'd7, -1, -1, "after_kill");

    for (int i = 0; i < 40; i++) begin
      s = codes[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run(s, a, b, -1, -1, "rand");
    end

    start = 1'b1; sel = C_MULHU; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_res", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    start = 1'b1; sel = C_ADD; op_a = 32'd3; op_b = 32'd4;
    #1 chk("add_busy0", busy, 1'b0);
    @(negedge clk);
    chk("add_busy1", busy, 1'b0);
    chk("add_done", done, 1'b0);
    start = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
